// File: rtl/plot_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// plot_cmd_sequencer
//   Drains the UART RX byte FIFO (first-word-fall-through) and assembles framed
//   plotter commands for the motion controller.
//   Frame: SYNC, OP, XH, XL, YH, YL, CHK where CHK = OP^XH^XL^YH^YL.
//   Bad checksums and stalled frames are dropped with a one-cycle error pulse.
//   Backpressure is applied by withholding pops while a command is pending.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   fifo_empty   RX FIFO empty flag
//   fifo_data    RX FIFO head byte, valid while !fifo_empty
//   fifo_pop     consume head byte this cycle (combinational)
//   cmd_valid    command available
//   cmd_ready    motion controller accepts command
//   cmd_op       opcode
//   cmd_x        X target {XH,XL}
//   cmd_y        Y target {YH,YL}
//   err_chk      one-cycle pulse on checksum mismatch
//   err_timeout  one-cycle pulse on intra-frame timeout
//   pkt_count    accepted-command count, wraps
// -----------------------------------------------------------------------------
module plot_cmd_sequencer #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [7:0]       fifo_data,
   output logic             fifo_pop,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [7:0]       cmd_op,
   output logic [15:0]      cmd_x,
   output logic [15:0]      cmd_y,
   output logic             err_chk,
   output logic             err_timeout,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_HUNT  = 3'd0;
   localparam logic [2:0] S_OP    = 3'd1;
   localparam logic [2:0] S_XH    = 3'd2;
   localparam logic [2:0] S_XL    = 3'd3;
   localparam logic [2:0] S_YH    = 3'd4;
   localparam logic [2:0] S_YL    = 3'd5;
   localparam logic [2:0] S_CHK   = 3'd6;
   localparam logic [2:0] S_ISSUE = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [7:0]       op_q, op_d;
   logic [7:0]       xh_q, xh_d;
   logic [7:0]       xl_q, xl_d;
   logic [7:0]       yh_q, yh_d;
   logic [7:0]       yl_q, yl_d;
   logic [7:0]       cmd_op_q, cmd_op_d;
   logic [15:0]      cmd_x_q, cmd_x_d;
   logic [15:0]      cmd_y_q, cmd_y_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             err_chk_q, err_chk_d;
   logic             err_timeout_q, err_timeout_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

   logic             pop_c;
   logic             in_frame_c;
   logic [7:0]       chk_calc_c;

   // Pop whenever a byte is available, except while a command waits for ready.
   assign pop_c      = (state_q != S_ISSUE) && !fifo_empty;
   assign in_frame_c = (state_q != S_HUNT) && (state_q != S_ISSUE);
   assign chk_calc_c = op_q ^ xh_q ^ xl_q ^ yh_q ^ yl_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_HUNT;
         op_q          <= '0;
         xh_q          <= '0;
         xl_q          <= '0;
         yh_q          <= '0;
         yl_q          <= '0;
         cmd_op_q      <= '0;
         cmd_x_q       <= '0;
         cmd_y_q       <= '0;
         cmd_valid_q   <= 1'b0;
         err_chk_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         pkt_count_q   <= '0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         xh_q          <= xh_d;
         xl_q          <= xl_d;
         yh_q          <= yh_d;
         yl_q          <= yl_d;
         cmd_op_q      <= cmd_op_d;
         cmd_x_q       <= cmd_x_d;
         cmd_y_q       <= cmd_y_d;
         cmd_valid_q   <= cmd_valid_d;
         err_chk_q     <= err_chk_d;
         err_timeout_q <= err_timeout_d;
         pkt_count_q   <= pkt_count_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      xh_d          = xh_q;
      xl_d          = xl_q;
      yh_d          = yh_q;
      yl_d          = yl_q;
      cmd_op_d      = cmd_op_q;
      cmd_x_d       = cmd_x_q;
      cmd_y_d       = cmd_y_q;
      cmd_valid_d   = cmd_valid_q;
      err_chk_d     = 1'b0;
      err_timeout_d = 1'b0;
      pkt_count_d   = pkt_count_q;
      to_cnt_d      = '0;

      // Idle counter only runs inside a frame; any pop restarts it.
      if (in_frame_c && fifo_empty) begin
         if (to_cnt_q == TO_LAST) begin
            state_d       = S_HUNT;
            err_timeout_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end

      case (state_q)
         S_HUNT: begin
            if (pop_c && (fifo_data == SYNC_BYTE)) begin
               state_d = S_OP;
            end
         end
         S_OP: begin
            if (pop_c) begin
               op_d    = fifo_data;
               state_d = S_XH;
            end
         end
         S_XH: begin
            if (pop_c) begin
               xh_d    = fifo_data;
               state_d = S_XL;
            end
         end
         S_XL: begin
            if (pop_c) begin
               xl_d    = fifo_data;
               state_d = S_YH;
            end
         end
         S_YH: begin
            if (pop_c) begin
               yh_d    = fifo_data;
               state_d = S_YL;
            end
         end
         S_YL: begin
            if (pop_c) begin
               yl_d    = fifo_data;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (pop_c) begin
               if (fifo_data == chk_calc_c) begin
                  // Publish the frame only once it is known good.
                  cmd_op_d    = op_q;
                  cmd_x_d     = {xh_q, xl_q};
                  cmd_y_d     = {yh_q, yl_q};
                  cmd_valid_d = 1'b1;
                  state_d     = S_ISSUE;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_HUNT;
               end
            end
         end
         S_ISSUE: begin
            if (cmd_valid_q && cmd_ready) begin
               cmd_valid_d = 1'b0;
               pkt_count_d = pkt_count_q + CNT_W'(1);
               state_d     = S_HUNT;
            end
         end
         default: begin
            state_d = S_HUNT;
         end
      endcase
   end

   assign fifo_pop    = pop_c;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_op      = cmd_op_q;
   assign cmd_x       = cmd_x_q;
   assign cmd_y       = cmd_y_q;
   assign err_chk     = err_chk_q;
   assign err_timeout = err_timeout_q;
   assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_plot_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_plot_cmd_sequencer
//   Directed bench for plot_cmd_sequencer: a queue models the FWFT RX FIFO,
//   a negedge monitor counts handshakes and error pulses.
// -----------------------------------------------------------------------------
module tb_plot_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_pop;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_x;
   logic [15:0] cmd_y;
   logic        err_chk;
   logic        err_timeout;
   logic [15:0] pkt_count;

   plot_cmd_sequencer #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (16),
      .CNT_W          (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_pop    (fifo_pop),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .err_chk     (err_chk),
      .err_timeout (err_timeout),
      .pkt_count   (pkt_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];
   int  cyc = 0;
   int  pop_cnt = 0;
   int  last_pop_cyc = 0;
   int  hs_cnt = 0;
   int  ec_cnt = 0;
   int  et_cnt = 0;
   int  to_cyc = 0;
   logic [7:0]  last_op = 8'h00;
   logic [15:0] last_x = 16'h0000;
   logic [15:0] last_y = 16'h0000;

   int b_hs, b_ec, b_et, b_pop;

   always @(posedge clk) cyc = cyc + 1;

   // FIFO model: the pop decided during a cycle takes effect just after its edge.
   always begin : fifo_model
      logic pend;
      @(negedge clk);
      pend = fifo_pop && !rst;
      @(posedge clk);
      #1;
      if (pend && q.size() > 0) begin
         void'(q.pop_front());
         pop_cnt      = pop_cnt + 1;
         last_pop_cyc = cyc;
      end
      fifo_empty = (q.size() == 0);
      fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
   end

   // Monitor on the inactive edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            hs_cnt  = hs_cnt + 1;
            last_op = cmd_op;
            last_x  = cmd_x;
            last_y  = cmd_y;
         end
         if (err_chk) ec_cnt = ec_cnt + 1;
         if (err_timeout) begin
            et_cnt = et_cnt + 1;
            to_cyc = cyc;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] op, input logic [7:0] xh, input logic [7:0] xl,
                             input logic [7:0] yh, input logic [7:0] yl, input logic [7:0] chk);
      q.push_back(8'hA5);
      q.push_back(op);
      q.push_back(xh);
      q.push_back(xl);
      q.push_back(yh);
      q.push_back(yl);
      q.push_back(chk);
   endtask

   task automatic push_good();
      push_frame(8'h01, 8'h00, 8'h64, 8'h00, 8'hC8, 8'hAD);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      cmd_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      b_hs  = hs_cnt;
      b_ec  = ec_cnt;
      b_et  = et_cnt;
      b_pop = pop_cnt;
   endtask

   task automatic wait_hs(input int n, input string tag);
      int k = 0;
      while ((hs_cnt - b_hs) < n && k < 200) begin
         tick();
         k++;
      end
      check_eq(tag, 32'(hs_cnt - b_hs), 32'(n));
   endtask

   task automatic check_good_cmd(input string tag);
      check_eq({tag, "_op"}, 32'(last_op), 32'h01);
      check_eq({tag, "_x"}, 32'(last_x), 32'h0064);
      check_eq({tag, "_y"}, 32'(last_y), 32'h00C8);
   endtask

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_valid", 32'(cmd_valid), 0);
      check_eq("rst_pop", 32'(fifo_pop), 0);
      check_eq("rst_op", 32'(cmd_op), 0);
      check_eq("rst_x", 32'(cmd_x), 0);
      check_eq("rst_y", 32'(cmd_y), 0);
      check_eq("rst_pkt", 32'(pkt_count), 0);
      check_eq("rst_errs", 32'({err_chk, err_timeout}), 0);

      // 1: single good frame
      push_good();
      wait_hs(1, "t1_hs");
      check_good_cmd("t1");
      check_eq("t1_pkt", 32'(pkt_count), 1);
      check_eq("t1_pops", 32'(pop_cnt - b_pop), 7);
      check_eq("t1_valid_drop", 32'(cmd_valid), 0);

      // 2: garbage before sync is dropped silently
      do_reset();
      q.push_back(8'h00);
      q.push_back(8'hFF);
      q.push_back(8'h3C);
      push_good();
      wait_hs(1, "t2_hs");
      repeat (5) tick();
      check_eq("t2_hs_once", 32'(hs_cnt - b_hs), 1);
      check_good_cmd("t2");
      check_eq("t2_pops", 32'(pop_cnt - b_pop), 10);
      check_eq("t2_errs", 32'((ec_cnt - b_ec) + (et_cnt - b_et)), 0);
      check_eq("t2_pkt", 32'(pkt_count), 1);

      // 3: bad checksum frame then good frame
      do_reset();
      push_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
      push_good();
      wait_hs(1, "t3_hs");
      repeat (5) tick();
      check_eq("t3_hs_once", 32'(hs_cnt - b_hs), 1);
      check_eq("t3_err_chk", 32'(ec_cnt - b_ec), 1);
      check_eq("t3_err_to", 32'(et_cnt - b_et), 0);
      check_good_cmd("t3");
      check_eq("t3_pkt", 32'(pkt_count), 1);

      // 4: backpressure, with a trailing byte waiting in the FIFO
      do_reset();
      cmd_ready = 1'b0;
      push_good();
      q.push_back(8'h00);
      begin
         int k = 0;
         while (!cmd_valid && k < 50) begin
            tick();
            k++;
         end
      end
      check_eq("t4_valid_up", 32'(cmd_valid), 1);
      for (int i = 0; i < 20; i++) begin
         check_eq("t4_hold_pop", 32'({cmd_valid, fifo_pop}), 32'h2);
         tick();
      end
      check_eq("t4_hold_op", 32'(cmd_op), 32'h01);
      check_eq("t4_hold_x", 32'(cmd_x), 32'h0064);
      check_eq("t4_hold_y", 32'(cmd_y), 32'h00C8);
      check_eq("t4_pkt_before", 32'(pkt_count), 0);
      cmd_ready = 1'b1;
      tick();
      check_eq("t4_pop_resume", 32'(fifo_pop), 1);
      check_eq("t4_valid_drop", 32'(cmd_valid), 0);
      check_eq("t4_pkt", 32'(pkt_count), 1);

      // 5: stall inside a frame triggers timeout after 16 idle cycles
      do_reset();
      q.push_back(8'hA5);
      q.push_back(8'h01);
      begin
         int k = 0;
         while ((et_cnt - b_et) == 0 && k < 60) begin
            tick();
            k++;
         end
      end
      check_eq("t5_err_to", 32'(et_cnt - b_et), 1);
      check_eq("t5_to_delay", 32'(to_cyc - last_pop_cyc), 16);
      push_good();
      wait_hs(1, "t5_hs");
      check_good_cmd("t5");
      check_eq("t5_pkt", 32'(pkt_count), 1);
      check_eq("t5_err_chk", 32'(ec_cnt - b_ec), 0);

      // 6: reset mid-frame
      do_reset();
      q.push_back(8'hA5);
      q.push_back(8'h01);
      q.push_back(8'h00);
      begin
         int k = 0;
         while ((pop_cnt - b_pop) < 3 && k < 20) begin
            tick();
            k++;
         end
      end
      check_eq("t6_pre_pops", 32'(pop_cnt - b_pop), 3);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_valid", 32'(cmd_valid), 0);
      check_eq("t6_rst_fields", 32'({cmd_op, cmd_x, cmd_y} != 40'h0), 0);
      check_eq("t6_rst_pop", 32'(fifo_pop), 0);
      tick();
      rst = 1'b0;
      b_hs  = hs_cnt;
      b_ec  = ec_cnt;
      b_et  = et_cnt;
      q.push_back(8'h64);
      q.push_back(8'h00);
      q.push_back(8'hC8);
      q.push_back(8'hAD);
      push_good();
      wait_hs(1, "t6_hs");
      repeat (3) tick();
      check_eq("t6_hs_once", 32'(hs_cnt - b_hs), 1);
      check_good_cmd("t6");
      check_eq("t6_pkt", 32'(pkt_count), 1);
      check_eq("t6_errs", 32'((ec_cnt - b_ec) + (et_cnt - b_et)), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
